// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised counter family.
// Holds direction/limit-mode encodings and a Gray-code helper.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic logic [31:0] gray_of(input logic [31:0] value);
    return value ^ (value >> 1);
  endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary to Gray converter, reusable by FIFO pointer logic.
module bin2gray
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  logic [31:0] gray_full;

  assign gray_full = gray_of(32'(bin));
  assign gray      = gray_full[WIDTH-1:0];

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter with configurable modulus, load, wrap/saturate and wrap pulse.
// Optional registered Gray output when PARAM_COUNTER_GRAY_OUT_EN is defined.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
`ifdef PARAM_COUNTER_GRAY_OUT_EN
  output logic [WIDTH-1:0] gray_out,
`endif
  output logic             wrap
);

  // Casting to WIDTH first keeps WIDTH=32 defaults correct despite int overflow.
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MAX_X = {1'b0, MAX_V};

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count == MAX_V);
  assign at_zero = (count == '0);
  assign sum     = {1'b0, count} + 1'b1;
  assign diff    = {1'b0, count} - 1'b1;

  assign tc = en & ((up_dn & at_max) | (~up_dn & at_zero));

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (load) begin
      count_nxt = ({1'b0, load_val} > MAX_X) ? MAX_V : load_val;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        if (sum <= MAX_X) begin
          count_nxt = sum[WIDTH-1:0];
        end else if (sat_mode == MODE_WRAP) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end
      end else begin
        // Borrow out of the extra bit means we were at zero.
        if (!diff[WIDTH]) begin
          count_nxt = diff[WIDTH-1:0];
        end else if (sat_mode == MODE_WRAP) begin
          count_nxt = MAX_V;
          wrap_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_V;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

`ifdef PARAM_COUNTER_GRAY_OUT_EN
  localparam logic [31:0] RST_GRAY_FULL = gray_of(32'(RESET_VAL));

  logic [WIDTH-1:0] gray_nxt;

  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .bin  (count_nxt),
    .gray (gray_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_out <= RST_GRAY_FULL[WIDTH-1:0];
    end else begin
      gray_out <= gray_nxt;
    end
  end
`endif

endmodule
